// File: rtl/table_writer_pkg.sv
// Shared definitions for the table write-side initiator: FSM state encoding
// and its width.
package table_writer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    VRD  = 2'd2,
    VCMP = 2'd3
  } state_e;

endpackage : table_writer_pkg

// File: rtl/table_writer_verify.sv
// Read-back checker for single-entry table writes.
// It saves the address and data of each accepted write and issues one read of
// that address. The data comes back one cycle after the read and is compared
// then. The error flag is sticky, and the address of the first mismatch is kept.
module table_writer_verify
  import table_writer_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_i,       // single-entry write accepted
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 rd_issue_i,  // FSM is in VRD
  input  logic [WIDTH-1:0]     dout_i,      // table read data
  output logic                 rd_o,
  output logic [ADDR_BITS-1:0] idx_o,
  output logic                 err_o,
  output logic [ADDR_BITS-1:0] err_addr_o
);

  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]     data_q;
  logic                 rd_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 pend_q;
  logic                 err_q;
  logic [ADDR_BITS-1:0] err_addr_q;
  logic                 mismatch_d;

  // Read data is valid in the cycle after Rd, which is when pend_q is high.
  assign mismatch_d = pend_q && (dout_i != data_q);

  // Save the write, issue the read, compare the returned data and record errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (cap_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
      rd_q   <= rd_issue_i;
      idx_q  <= rd_issue_i ? addr_q : '0;
      pend_q <= rd_q;
      if (mismatch_d) begin
        err_q <= 1'b1;
        if (!err_q) begin
          err_addr_q <= addr_q;
        end
      end
    end
  end

  assign rd_o       = rd_q;
  assign idx_o      = idx_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule : table_writer_verify

// File: rtl/table_writer.sv
// Write-side initiator for the router's synchronous 1R1W lookup tables.
// It handles single-entry writes over a valid/ready stream and a bulk fill of
// every entry with one value.
// Optional feature macro: TABLE_WRITER_VERIFY_EN. When it is defined, each
// single-entry write is read back and checked.
module table_writer
  import table_writer_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 9,
  parameter int DEPTH     = 1 << ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 fill_start,
  input  logic [WIDTH-1:0]     fill_value,
  output logic                 busy,
  output logic                 fill_done,
  output logic                 We,
  output logic [ADDR_BITS-1:0] IdxW,
  output logic [WIDTH-1:0]     DinW,
  output logic                 Rd,
  output logic [ADDR_BITS-1:0] IdxR,
  input  logic [WIDTH-1:0]     DoutR,
  output logic                 verify_err,
  output logic [ADDR_BITS-1:0] err_addr
);

  // Last fill address. The fill counter stops here, so it never walks past
  // DEPTH-1 even when DEPTH is not a power of two.
  localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(DEPTH - 1);

  state_e               state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic [WIDTH-1:0]     fill_val_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] idxw_q;
  logic [WIDTH-1:0]     dinw_q;
  logic                 fill_done_q;
  logic                 hs_d;

  // Requests are accepted only in IDLE and only when no fill starts that cycle.
  // Reset also holds ready low.
  assign wr_ready = (state_q == IDLE) && !fill_start && !rst;
  assign hs_d     = wr_valid && wr_ready;
  assign busy     = (state_q != IDLE);

  // Main FSM: it issues single writes and fill writes through registered port signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      we_q        <= 1'b0;
      idxw_q      <= '0;
      dinw_q      <= '0;
      fill_done_q <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start) begin
            fill_val_q <= fill_value;
            cnt_q      <= '0;
            state_q    <= FILL;
          end else if (hs_d) begin
            we_q   <= 1'b1;
            idxw_q <= wr_addr;
            dinw_q <= wr_data;
`ifdef TABLE_WRITER_VERIFY_EN
            state_q <= VRD;
`endif
          end
        end
        FILL: begin
          we_q   <= 1'b1;
          idxw_q <= cnt_q;
          dinw_q <= fill_val_q;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            fill_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + ADDR_BITS'(1);
          end
        end
`ifdef TABLE_WRITER_VERIFY_EN
        // VRD registers the read request, so Rd is seen during VCMP. This is
        // one cycle after the write has landed in the table.
        VRD:     state_q <= VCMP;
        VCMP:    state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign We        = we_q;
  assign IdxW      = idxw_q;
  assign DinW      = dinw_q;
  assign fill_done = fill_done_q;

`ifdef TABLE_WRITER_VERIFY_EN
  table_writer_verify #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_verify (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (hs_d),
    .addr_i     (wr_addr),
    .data_i     (wr_data),
    .rd_issue_i (state_q == VRD),
    .dout_i     (DoutR),
    .rd_o       (Rd),
    .idx_o      (IdxR),
    .err_o      (verify_err),
    .err_addr_o (err_addr)
  );
`else
  // Without read-back the read port stays idle and DoutR is ignored.
  logic unused_doutr;
  assign unused_doutr = ^DoutR;
  assign Rd           = 1'b0;
  assign IdxR         = '0;
  assign verify_err   = 1'b0;
  assign err_addr     = '0;
`endif

endmodule : table_writer

// File: tb/tb_table_writer.sv
// Directed bench for table_writer (WIDTH=8, ADDR_BITS=2, DEPTH=4).
// The table is modelled as a RAM with a 1-cycle read.
// Read-back checks run when TABLE_WRITER_VERIFY_EN is defined.
module tb_table_writer;

  localparam int W  = 8;
  localparam int AB = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AB-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          fill_start = 1'b0;
  logic [W-1:0]  fill_value = '0;
  logic          busy, fill_done, We, Rd, verify_err;
  logic [AB-1:0] IdxW, IdxR, err_addr;
  logic [W-1:0]  DinW, DoutR;

  int tests_run    = 0;
  int tests_failed = 0;

  // Table model. corrupt_req overwrites an entry after any write on the same edge.
  logic [W-1:0]  ram [D];
  logic [W-1:0]  dout_q = '0;
  logic          corrupt_req = 1'b0;
  logic [AB-1:0] corrupt_addr = '0;

  always #5 clk = ~clk;

  // Model of the table: write port, optional corruption and a registered read.
  always @(posedge clk) begin
    if (We) ram[IdxW] <= DinW;
    if (corrupt_req) ram[corrupt_addr] <= '0;
    if (Rd) dout_q <= ram[IdxR];
  end
  assign DoutR = dout_q;

  table_writer #(.WIDTH(W), .ADDR_BITS(AB), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .busy       (busy),
    .fill_done  (fill_done),
    .We         (We),
    .IdxW       (IdxW),
    .DinW       (DinW),
    .Rd         (Rd),
    .IdxR       (IdxR),
    .DoutR      (DoutR),
    .verify_err (verify_err),
    .err_addr   (err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one write, wait (bounded) for acceptance, and check the port pulse.
  task automatic do_write(input logic [AB-1:0] a, input logic [W-1:0] d);
    bit ok = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (wr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("wr_ready_timeout", 0, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("wr_we", 32'(We), 1);
    check("wr_idxw", 32'(IdxW), 32'(a));
    check("wr_dinw", 32'(DinW), 32'(d));
    $display("[TB] write addr=%0d data=%02h", a, d);
  endtask

  // Run fill cycles k=1..5 after fill_start is sampled (the caller checks k=6).
  task automatic fill_seq(input logic [W-1:0] v, input bit pend_wr);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      check("fill_busy", 32'(busy), (k <= 4) ? 1 : 0);
      check("fill_we", 32'(We), (k >= 2) ? 1 : 0);
      check("fill_done", 32'(fill_done), (k == 5) ? 1 : 0);
      if (k >= 2) begin
        check("fill_idxw", 32'(IdxW), 32'(k - 2));
        check("fill_dinw", 32'(DinW), 32'(v));
      end
      if (k == 5 && pend_wr) begin
        #1;
        check("post_fill_ready", 32'(wr_ready), 1);
      end
    end
    $display("[TB] fill value=%02h done", v);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_we", 32'(We), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fill_done", 32'(fill_done), 0);
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_rd", 32'(Rd), 0);
    check("rst_verr", 32'(verify_err), 0);
    check("rst_erraddr", 32'(err_addr), 0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(wr_ready), 1);
    $display("[TB] reset released");

    // Single writes (1,A5) then (3,3C)
`ifndef TABLE_WRITER_VERIFY_EN
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'hA5;
    @(negedge clk);
    check("b2b_we0", 32'(We), 1);
    check("b2b_idx0", 32'(IdxW), 1);
    check("b2b_din0", 32'(DinW), 'hA5);
    wr_addr = 2'd3; wr_data = 8'h3C;
    #1;
    check("b2b_ready", 32'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("b2b_we1", 32'(We), 1);
    check("b2b_idx1", 32'(IdxW), 3);
    check("b2b_din1", 32'(DinW), 'h3C);
    check("noverify_rd", 32'(Rd), 0);
    check("noverify_idxr", 32'(IdxR), 0);
    $display("[TB] back-to-back writes (1,a5) (3,3c)");
    @(negedge clk);
    check("b2b_we_off", 32'(We), 0);
`else
    do_write(2'd1, 8'hA5);
    do_write(2'd3, 8'h3C);
    repeat (4) @(negedge clk);
    check("wr_verr", 32'(verify_err), 0);
`endif
    @(negedge clk);
    check("ram1", 32'(ram[1]), 'hA5);
    check("ram3", 32'(ram[3]), 'h3C);

    // Bulk fill with 0x5A
    fill_start = 1'b1; fill_value = 8'h5A;
    #1;
    check("fill_ready", 32'(wr_ready), 0);
    fill_seq(8'h5A, 0);
    @(negedge clk);
    check("fill_end_we", 32'(We), 0);
    check("fill_end_done", 32'(fill_done), 0);
    for (int i = 0; i < D; i++) check("fill_ram", 32'(ram[i]), 'h5A);

    // fill_start and wr_valid together: the write waits until after the fill
    fill_start = 1'b1; fill_value = 8'hC3;
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'h99;
    #1;
    check("conflict_ready", 32'(wr_ready), 0);
    fill_seq(8'hC3, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("late_we", 32'(We), 1);
    check("late_idxw", 32'(IdxW), 2);
    check("late_dinw", 32'(DinW), 'h99);
    $display("[TB] write (2,99) accepted after fill");
    repeat (4) @(negedge clk);
    check("late_ram2", 32'(ram[2]), 'h99);
    check("late_ram3", 32'(ram[3]), 'hC3);

    // Reset after the 2nd fill write
    fill_start = 1'b1; fill_value = 8'hE7;
    @(negedge clk);
    fill_start = 1'b0;
    @(negedge clk);
    check("rf_idx0", 32'(IdxW), 0);
    @(negedge clk);
    check("rf_idx1", 32'(IdxW), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rf_we", 32'(We), 0);
    check("rf_busy", 32'(busy), 0);
    check("rf_done", 32'(fill_done), 0);
    check("rf_idxw", 32'(IdxW), 0);
    check("rf_dinw", 32'(DinW), 0);
    check("rf_ready", 32'(wr_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rf_done2", 32'(fill_done), 0);
    check("rf_we2", 32'(We), 0);
    check("rf_ram0", 32'(ram[0]), 'hE7);
    check("rf_ram1", 32'(ram[1]), 'hE7);
    check("rf_ram2", 32'(ram[2]), 'h99);
    check("rf_ram3", 32'(ram[3]), 'hC3);
    $display("[TB] reset during fill");

`ifdef TABLE_WRITER_VERIFY_EN
    // Clean read-back of (2,77)
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'h77;
    #1;
    check("v1_ready", 32'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("v1_we", 32'(We), 1);
    check("v1_rd_early", 32'(Rd), 0);
    #1;
    check("v1_busy_ready", 32'(wr_ready), 0);
    @(negedge clk);
    check("v1_rd", 32'(Rd), 1);
    check("v1_idxr", 32'(IdxR), 2);
    @(negedge clk);
    #1;
    check("v1_ready_back", 32'(wr_ready), 1);
    @(negedge clk);
    check("v1_verr", 32'(verify_err), 0);
    $display("[TB] verify write (2,77) clean");

    // Corrupted read-back at addr 2
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'h11;
    @(negedge clk);
    wr_valid = 1'b0;
    corrupt_req = 1'b1; corrupt_addr = 2'd2;
    @(negedge clk);
    corrupt_req = 1'b0;
    check("v2_rd", 32'(Rd), 1);
    repeat (2) @(negedge clk);
    check("v2_verr", 32'(verify_err), 1);
    check("v2_erraddr", 32'(err_addr), 2);
    $display("[TB] verify write (2,11) corrupted");

    // Second mismatch at addr 1 keeps the first address
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h22;
    @(negedge clk);
    wr_valid = 1'b0;
    corrupt_req = 1'b1; corrupt_addr = 2'd1;
    @(negedge clk);
    corrupt_req = 1'b0;
    check("v3_idxr", 32'(IdxR), 1);
    repeat (2) @(negedge clk);
    check("v3_verr", 32'(verify_err), 1);
    check("v3_erraddr", 32'(err_addr), 2);
    $display("[TB] verify write (1,22) corrupted");
`else
    check("nv_verr", 32'(verify_err), 0);
    check("nv_erraddr", 32'(err_addr), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: stops the run if the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_table_writer
